// File: rtl/generic_fifo_pkg.sv
// ----------------------------------------------------------------------------
// generic_fifo_pkg
// Shared definitions for the generic FIFO family (single-clock and 2clk
// envelopes).
//   - DEF_PTR_WIDTH / CNT_WIDTH : default pointer width and occupancy width.
//   - fifo_err_e                : error code. Bit 0 means a write was attempted
//                                 while full; bit 1 means a read was attempted
//                                 while empty.
//   - ptr_inc()                 : pointer increment that wraps at an arbitrary
//                                 depth, which need not be a power of two.
// ----------------------------------------------------------------------------
package generic_fifo_pkg;

   localparam int DEF_PTR_WIDTH = 3;
   localparam int CNT_WIDTH     = DEF_PTR_WIDTH + 1;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'b00,
      ERR_FULL  = 2'b01,
      ERR_EMPTY = 2'b10,
      ERR_BOTH  = 2'b11
   } fifo_err_e;

   // The last legal slot (depth-1) wraps to 0. The depth may be any integer.
   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage : generic_fifo_pkg

// File: rtl/generic_sync_fifo_thr_if.sv
// ----------------------------------------------------------------------------
// generic_sync_fifo_thr_if
// Handshake and status bundle for generic_sync_fifo_thr.
//   master : the user side. It drives flush, wr_op, wr_data, wr_mask, rd_op
//            and the thresholds, and observes data and status.
//   slave  : the FIFO side. It drives rd_data, rd_valid, the flags,
//            entry_used and the error pulses.
// ----------------------------------------------------------------------------
interface generic_sync_fifo_thr_if #(
   parameter int PTR_WIDTH = 3,
   parameter int DAT_WIDTH = 50
);
   logic                 flush;
   logic                 wr_op;
   logic [DAT_WIDTH-1:0] wr_data;
   logic [DAT_WIDTH-1:0] wr_mask;
   logic                 rd_op;
   logic [DAT_WIDTH-1:0] rd_data;
   logic                 rd_valid;
   logic [PTR_WIDTH:0]   afull_thr;
   logic [PTR_WIDTH:0]   aempty_thr;
   logic                 full;
   logic                 empty;
   logic                 almost_full;
   logic                 almost_empty;
   logic [PTR_WIDTH:0]   entry_used;
   logic                 full_err;
   logic                 empty_err;

   modport master (
      output flush, wr_op, wr_data, wr_mask, rd_op, afull_thr, aempty_thr,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             entry_used, full_err, empty_err
   );

   modport slave (
      input  flush, wr_op, wr_data, wr_mask, rd_op, afull_thr, aempty_thr,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             entry_used, full_err, empty_err
   );
endinterface : generic_sync_fifo_thr_if

// File: rtl/generic_sync_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// generic_sync_fifo_ctrl
// Pointer, occupancy, flag and error bookkeeping for generic_sync_fifo_thr.
// Ports:
//   clk, reset            : clock and asynchronous active-high reset.
//   flush_i               : synchronous clear. It overrides any same-cycle
//                           operation and raises no error.
//   wr_op_i, rd_op_i      : requests. Acceptance is gated by the registered
//                           full and empty flags of the current cycle.
//   afull_thr_i/aempty_thr_i : thresholds, compared against the next-state count.
//   wr_acc_o, rd_acc_o    : accepted operations, used by the storage.
//   wr_ptr_o, rd_ptr_o    : slot addresses.
//   full_o .. entry_used_o: registered status.
//   full_err_o/empty_err_o: registered one-cycle error pulses.
// ----------------------------------------------------------------------------
module generic_sync_fifo_ctrl
   import generic_fifo_pkg::*;
#(
   parameter int PTR_WIDTH      = 3,
   parameter int NUM_OF_ENTRIES = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush_i,
   input  logic                 wr_op_i,
   input  logic                 rd_op_i,
   input  logic [PTR_WIDTH:0]   afull_thr_i,
   input  logic [PTR_WIDTH:0]   aempty_thr_i,
   output logic                 wr_acc_o,
   output logic                 rd_acc_o,
   output logic [PTR_WIDTH-1:0] wr_ptr_o,
   output logic [PTR_WIDTH-1:0] rd_ptr_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic                 almost_full_o,
   output logic                 almost_empty_o,
   output logic [PTR_WIDTH:0]   entry_used_o,
   output logic                 full_err_o,
   output logic                 empty_err_o
);

   localparam int               CW    = PTR_WIDTH + 1;
   localparam logic [CW-1:0]    DEPTH = CW'(NUM_OF_ENTRIES);

   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 full_q, empty_q, afull_q, aempty_q;
   fifo_err_e            err_q, err_d;
   logic                 wr_acc, rd_acc;

   // Only the registered flags gate acceptance. A same-cycle pop never makes
   // room for a push, and a same-cycle push never feeds a pop.
   assign wr_acc = wr_op_i & ~full_q  & ~flush_i;
   assign rd_acc = rd_op_i & ~empty_q & ~flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      err_d    = ERR_NONE;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (wr_acc)
            wr_ptr_d = PTR_WIDTH'(ptr_inc(int'(wr_ptr_q), NUM_OF_ENTRIES));
         if (rd_acc)
            rd_ptr_d = PTR_WIDTH'(ptr_inc(int'(rd_ptr_q), NUM_OF_ENTRIES));
         case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
         err_d = fifo_err_e'({rd_op_i & empty_q, wr_op_i & full_q});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         err_q    <= ERR_NONE;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         // Flags follow the next-state count, so they line up with entry_used.
         full_q   <= (cnt_d == DEPTH);
         empty_q  <= (cnt_d == '0);
         afull_q  <= (cnt_d >= afull_thr_i);
         aempty_q <= (cnt_d <= aempty_thr_i);
         err_q    <= err_d;
      end
   end

   assign wr_acc_o       = wr_acc;
   assign rd_acc_o       = rd_acc;
   assign wr_ptr_o       = wr_ptr_q;
   assign rd_ptr_o       = rd_ptr_q;
   assign full_o         = full_q;
   assign empty_o        = empty_q;
   assign almost_full_o  = afull_q;
   assign almost_empty_o = aempty_q;
   assign entry_used_o   = cnt_q;
   assign full_err_o     = (err_q == ERR_FULL)  || (err_q == ERR_BOTH);
   assign empty_err_o    = (err_q == ERR_EMPTY) || (err_q == ERR_BOTH);

endmodule : generic_sync_fifo_ctrl

// File: rtl/generic_sync_fifo_thr.sv
// ----------------------------------------------------------------------------
// generic_sync_fifo_thr
// Single-clock FIFO built on a flop array. It has a per-bit write mask,
// programmable almost-full and almost-empty thresholds, a synchronous flush
// and registered error pulses. The depth may be any value from 2 to
// 2^PTR_WIDTH.
// Ports:
//   clk     : clock. All logic runs on the rising edge.
//   reset   : asynchronous active-high reset. Storage is not cleared.
//   fifo_if : generic_sync_fifo_thr_if.slave. It carries the requests, data,
//             thresholds and status.
// Build option:
//   GENERIC_SYNC_FIFO_FWFT_EN defined   : first-word-fall-through. rd_data
//                                         always shows the head word,
//                                         rd_valid = ~empty, and rd_op pops
//                                         with zero latency.
//   GENERIC_SYNC_FIFO_FWFT_EN undefined : registered read with one cycle of
//                                         latency.
// ----------------------------------------------------------------------------
module generic_sync_fifo_thr
   import generic_fifo_pkg::*;
#(
   parameter int PTR_WIDTH      = 3,
   parameter int NUM_OF_ENTRIES = 8,
   parameter int DAT_WIDTH      = 50
) (
   input  logic                   clk,
   input  logic                   reset,
   generic_sync_fifo_thr_if.slave fifo_if
);

   logic                 wr_acc, rd_acc;
   logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic                 empty;
   logic [DAT_WIDTH-1:0] head_word;
   logic [DAT_WIDTH-1:0] mem_q [NUM_OF_ENTRIES];

   generic_sync_fifo_ctrl #(
      .PTR_WIDTH      (PTR_WIDTH),
      .NUM_OF_ENTRIES (NUM_OF_ENTRIES)
   ) u_ctrl (
      .clk            (clk),
      .reset          (reset),
      .flush_i        (fifo_if.flush),
      .wr_op_i        (fifo_if.wr_op),
      .rd_op_i        (fifo_if.rd_op),
      .afull_thr_i    (fifo_if.afull_thr),
      .aempty_thr_i   (fifo_if.aempty_thr),
      .wr_acc_o       (wr_acc),
      .rd_acc_o       (rd_acc),
      .wr_ptr_o       (wr_ptr),
      .rd_ptr_o       (rd_ptr),
      .full_o         (fifo_if.full),
      .empty_o        (empty),
      .almost_full_o  (fifo_if.almost_full),
      .almost_empty_o (fifo_if.almost_empty),
      .entry_used_o   (fifo_if.entry_used),
      .full_err_o     (fifo_if.full_err),
      .empty_err_o    (fifo_if.empty_err)
   );

   assign fifo_if.empty = empty;

   // Masked write: bits whose mask is 0 keep what the slot already held.
   always_ff @(posedge clk) begin
      if (wr_acc)
         mem_q[wr_ptr] <= (fifo_if.wr_data & fifo_if.wr_mask) |
                          (mem_q[wr_ptr] & ~fifo_if.wr_mask);
   end

   assign head_word = mem_q[rd_ptr];

`ifdef GENERIC_SYNC_FIFO_FWFT_EN
   // The head is combinational from the array. While empty, rd_data is forced
   // to 0 so reset and flush never expose stale or uninitialised slots.
   assign fifo_if.rd_data  = empty ? '0 : head_word;
   assign fifo_if.rd_valid = ~empty;
`else
   logic [DAT_WIDTH-1:0] rd_data_q;
   logic                 rd_valid_q;

   // rd_acc is already low during a flush, so the same term also clears
   // rd_valid on flush. rd_data keeps the last popped word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc)
            rd_data_q <= head_word;
      end
   end

   assign fifo_if.rd_data  = rd_data_q;
   assign fifo_if.rd_valid = rd_valid_q;
`endif

endmodule : generic_sync_fifo_thr

// File: tb/tb_generic_sync_fifo_thr.sv
module tb_generic_sync_fifo_thr;
   localparam int PW = 3;
   localparam int N  = 6;
   localparam int DW = 50;
   localparam logic [DW-1:0] ONES = {DW{1'b1}};

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   generic_sync_fifo_thr_if #(.PTR_WIDTH(PW), .DAT_WIDTH(DW)) fif ();

   generic_sync_fifo_thr #(
      .PTR_WIDTH(PW), .NUM_OF_ENTRIES(N), .DAT_WIDTH(DW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .fifo_if (fif)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%h, wanted 0x%h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a circular slot array with modulo indices. It is kept
   // at slot level so the masked write can merge into the old contents.
   logic [DW-1:0] mm [N];
   int            wi = 0, ri = 0, cnt = 0;
   logic          e_valid = 0, e_ferr = 0, e_eerr = 0, e_af = 0, e_ae = 1;
   logic [DW-1:0] e_rdata = '0;

   initial for (int k = 0; k < N; k++) mm[k] = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         wi = 0; ri = 0; cnt = 0;
         e_valid = 0; e_ferr = 0; e_eerr = 0; e_af = 0; e_ae = 1;
         e_rdata = '0;
      end else begin
         if (fif.flush) begin
            wi = 0; ri = 0; cnt = 0;
            e_valid = 0; e_ferr = 0; e_eerr = 0;
         end else begin
            automatic bit was_full  = (cnt == N);
            automatic bit was_empty = (cnt == 0);
            automatic bit wa = fif.wr_op && !was_full;
            automatic bit ra = fif.rd_op && !was_empty;
            e_ferr  = fif.wr_op && was_full;
            e_eerr  = fif.rd_op && was_empty;
            e_valid = ra;
            if (ra) begin
               e_rdata = mm[ri];
               ri = (ri + 1) % N;
            end
            if (wa) begin
               mm[wi] = (fif.wr_data & fif.wr_mask) | (mm[wi] & ~fif.wr_mask);
               wi = (wi + 1) % N;
            end
            cnt = cnt + int'(wa) - int'(ra);
         end
         e_af = (cnt >= int'(fif.afull_thr));
         e_ae = (cnt <= int'(fif.aempty_thr));
      end
   end

   // Per-cycle compare against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         chk("m_used",   64'(fif.entry_used),   64'(cnt));
         chk("m_full",   64'(fif.full),         64'(cnt == N));
         chk("m_empty",  64'(fif.empty),        64'(cnt == 0));
         chk("m_afull",  64'(fif.almost_full),  64'(e_af));
         chk("m_aempty", 64'(fif.almost_empty), 64'(e_ae));
         chk("m_ferr",   64'(fif.full_err),     64'(e_ferr));
         chk("m_eerr",   64'(fif.empty_err),    64'(e_eerr));
`ifdef GENERIC_SYNC_FIFO_FWFT_EN
         chk("m_valid",  64'(fif.rd_valid),     64'(cnt != 0));
         if (cnt != 0) chk("m_data", 64'(fif.rd_data), 64'(mm[ri]));
`else
         chk("m_valid",  64'(fif.rd_valid),     64'(e_valid));
         chk("m_data",   64'(fif.rd_data),      64'(e_rdata));
`endif
      end
   end

   task automatic step(input logic w, input logic [DW-1:0] d, input logic [DW-1:0] m,
                       input logic r, input logic f);
      fif.wr_op = w; fif.wr_data = d; fif.wr_mask = m; fif.rd_op = r; fif.flush = f;
      @(posedge clk);
      #1;
      $display("txn t=%0t wr=%0b data=0x%h rd=%0b flush=%0b -> used=%0d rd_valid=%0b rd_data=0x%h",
               $time, w, d, r, f, fif.entry_used, fif.rd_valid, fif.rd_data);
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic push(input logic [DW-1:0] d);
      step(1'b1, d, ONES, 1'b0, 1'b0);
   endtask

   // In FWFT mode the head is checked before the pop edge (zero latency).
   // Otherwise it is checked after the edge (one cycle of latency).
   task automatic pop_expect(input string name, input logic [DW-1:0] exp,
                             input logic w, input logic [DW-1:0] d);
`ifdef GENERIC_SYNC_FIFO_FWFT_EN
      chk(name, 64'(fif.rd_data), 64'(exp));
      chk({name, "_v"}, 64'(fif.rd_valid), 64'd1);
      step(w, d, ONES, 1'b1, 1'b0);
`else
      step(w, d, ONES, 1'b1, 1'b0);
      chk(name, 64'(fif.rd_data), 64'(exp));
      chk({name, "_v"}, 64'(fif.rd_valid), 64'd1);
`endif
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_used"},   64'(fif.entry_used),   64'd0);
      chk({tag, "_empty"},  64'(fif.empty),        64'd1);
      chk({tag, "_full"},   64'(fif.full),         64'd0);
      chk({tag, "_aempty"}, 64'(fif.almost_empty), 64'd1);
      chk({tag, "_afull"},  64'(fif.almost_full),  64'd0);
      chk({tag, "_valid"},  64'(fif.rd_valid),     64'd0);
      chk({tag, "_data"},   64'(fif.rd_data),      64'd0);
      chk({tag, "_ferr"},   64'(fif.full_err),     64'd0);
      chk({tag, "_eerr"},   64'(fif.empty_err),    64'd0);
   endtask

   initial begin
      fif.flush = 0; fif.wr_op = 0; fif.wr_data = '0; fif.wr_mask = '0; fif.rd_op = 0;
      fif.afull_thr = 4'd5; fif.aempty_thr = 4'd1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("rst");
      #1 reset = 1'b0;

      // Fill, overfill, drain, then wrap.
      for (int i = 1; i <= 6; i++) push(DW'(i));
      chk("fill_used", 64'(fif.entry_used), 64'd6);
      chk("fill_full", 64'(fif.full), 64'd1);
      chk("fill_af",   64'(fif.almost_full), 64'd1);
      push(DW'(7));
      chk("ovf_ferr", 64'(fif.full_err), 64'd1);
      chk("ovf_used", 64'(fif.entry_used), 64'd6);
      idle();
      chk("ovf_ferr_clr", 64'(fif.full_err), 64'd0);
      for (int i = 1; i <= 6; i++) pop_expect("drain", DW'(i), 1'b0, '0);
      chk("drain_empty", 64'(fif.empty), 64'd1);
      push(DW'('h11));
      pop_expect("wrap", DW'('h11), 1'b0, '0);

      // Masked write into slot 0.
      step(0, '0, '0, 0, 1);
      push(ONES);
      pop_expect("ones", ONES, 1'b0, '0);
      step(0, '0, '0, 0, 1);
      step(1, '0, DW'('h3), 0, 0);
      pop_expect("masked", 50'h3FFFFFFFFFFFC, 1'b0, '0);

      // Simultaneous read and write at count 3, then at full.
      step(0, '0, '0, 0, 1);
      for (int i = 1; i <= 3; i++) push(DW'('h100 + i));
      for (int k = 1; k <= 4; k++) begin
         pop_expect("simul", (k <= 3) ? DW'('h100 + k) : DW'('h201), 1'b1, DW'('h200 + k));
         chk("simul_used", 64'(fif.entry_used), 64'd3);
      end
      for (int i = 1; i <= 3; i++) push(DW'('h300 + i));
      chk("sfull_full", 64'(fif.full), 64'd1);
      pop_expect("sfull_rd", DW'('h202), 1'b1, DW'('h3FF));
      chk("sfull_used", 64'(fif.entry_used), 64'd5);
      chk("sfull_ferr", 64'(fif.full_err), 64'd1);
      pop_expect("tail", DW'('h203), 1'b0, '0);
      pop_expect("tail", DW'('h204), 1'b0, '0);
      for (int i = 1; i <= 3; i++) pop_expect("tail", DW'('h300 + i), 1'b0, '0);

      // Thresholds.
      step(0, '0, '0, 0, 1);
      for (int i = 0; i < 4; i++) push(DW'('h40 + i));
      chk("thr_af4", 64'(fif.almost_full), 64'd0);
      push(DW'('h44));
      chk("thr_af5", 64'(fif.almost_full), 64'd1);
      fif.afull_thr = 4'd7;
      idle();
      chk("thr_af7", 64'(fif.almost_full), 64'd0);
      fif.afull_thr = 4'd5;
      idle();
      chk("thr_af_back", 64'(fif.almost_full), 64'd1);
      for (int i = 0; i < 3; i++) step(0, '0, '0, 1, 0);
      chk("thr_ae2", 64'(fif.almost_empty), 64'd0);
      step(0, '0, '0, 1, 0);
      chk("thr_ae1", 64'(fif.almost_empty), 64'd1);

      // Empty read, then flush with a write pending.
      step(0, '0, '0, 0, 1);
      step(0, '0, '0, 1, 0);
      chk("uf_eerr",  64'(fif.empty_err), 64'd1);
      chk("uf_valid", 64'(fif.rd_valid), 64'd0);
      idle();
      chk("uf_eerr_clr", 64'(fif.empty_err), 64'd0);
      for (int i = 0; i < 4; i++) push(DW'('h60 + i));
      step(1, DW'('h55), ONES, 0, 1);
      chk("fl_used",  64'(fif.entry_used), 64'd0);
      chk("fl_empty", 64'(fif.empty), 64'd1);
      chk("fl_ferr",  64'(fif.full_err), 64'd0);
      for (int i = 0; i < 6; i++) push(DW'('h70 + i));
      step(1, DW'('h77), ONES, 0, 1);
      chk("flfull_ferr", 64'(fif.full_err), 64'd0);
      chk("flfull_used", 64'(fif.entry_used), 64'd0);

      // Reset in the middle of a burst while rd_valid is high.
      for (int i = 0; i < 3; i++) push(DW'('h80 + i));
      step(0, '0, '0, 1, 0);
      chk("mid_valid", 64'(fif.rd_valid), 64'd1);
      fif.rd_op = 0;
      #2 reset = 1'b1;
      #1 chk_reset_vals("mid_rst");
      @(negedge clk);
      #1 reset = 1'b0;
      idle();
      chk("post_rst_used", 64'(fif.entry_used), 64'd0);
      push(DW'('h99));
      pop_expect("post_rst", DW'('h99), 1'b0, '0);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
